// File: rtl/fifo_rd_packer.sv
// Read-side packer: pops PACK FIFO words into one wide valid/ready beat (first word in LSBs).
// Optional partial-word flush after TIMEOUT idle cycles when PKT_TIMEOUT_EN is defined.
module fifo_rd_packer #(
   parameter int DSIZE   = 8,
   parameter int PACK    = 4,
   parameter int TIMEOUT = 16,
   parameter int CW      = 16
) (
   input  logic                  rclk,
   input  logic                  rrst_n,
   input  logic [DSIZE-1:0]      rdata,
   input  logic                  rempty,
   output logic                  rinc,
   output logic [DSIZE*PACK-1:0] out_data,
   output logic [PACK-1:0]       out_keep,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CW-1:0]         word_count
);

   localparam int CNTW = $clog2(PACK + 1);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_FULL} acc_state_e;

   logic [PACK-1:0][DSIZE-1:0] acc_q, acc_d, acc_part;
   logic [CNTW-1:0]            cnt_q, cnt_d, wr_idx;
   logic [DSIZE*PACK-1:0]      data_q, data_d;
   logic [PACK-1:0]            keep_q, keep_d, part_keep;
   logic                       valid_q, valid_d;
   logic [CW-1:0]              wc_q, wc_d;
   acc_state_e                 state;
   logic                       out_free, xfer, pop, flush;

   always_comb begin
      if (cnt_q == CNTW'(PACK))  state = S_FULL;
      else if (cnt_q == '0)      state = S_IDLE;
      else                       state = S_FILL;
   end

   assign out_free = !valid_q || out_ready;
   assign xfer     = (state == S_FULL) && out_free;
   // Popping while full is allowed only when the accumulator drains the same cycle.
   assign rinc     = rrst_n && !rempty && ((state != S_FULL) || xfer);
   assign pop      = rinc;

`ifdef PKT_TIMEOUT_EN
   localparam int IW = $clog2(TIMEOUT + 1);
   logic [IW-1:0] idle_q, idle_d;

   assign flush = (state == S_FILL) && (idle_q == IW'(TIMEOUT)) && out_free && !pop;

   always_comb begin
      idle_d = idle_q;
      if (pop || xfer || flush || state != S_FILL) idle_d = '0;
      else if (idle_q != IW'(TIMEOUT))             idle_d = idle_q + IW'(1);
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) idle_q <= '0;
      else         idle_q <= idle_d;
   end
`else
   assign flush = 1'b0;
`endif

   always_comb begin
      for (int i = 0; i < PACK; i++) begin
         part_keep[i] = (CNTW'(i) < cnt_q);
         acc_part[i]  = part_keep[i] ? acc_q[i] : '0;
      end
   end

   always_comb begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      keep_d  = keep_q;
      valid_d = valid_q;
      wc_d    = wc_q;
      wr_idx  = cnt_q;
      if (valid_q && out_ready) begin
         valid_d = 1'b0;
         wc_d    = wc_q + CW'(1);
      end
      if (xfer) begin
         data_d  = acc_q;
         keep_d  = '1;
         valid_d = 1'b1;
         cnt_d   = '0;
         wr_idx  = '0;
      end else if (flush) begin
         data_d  = acc_part;
         keep_d  = part_keep;
         valid_d = 1'b1;
         cnt_d   = '0;
      end
      // A pop during a drain lands in slot 0 of the freshly emptied accumulator.
      if (pop) begin
         for (int i = 0; i < PACK; i++)
            if (wr_idx == CNTW'(i)) acc_d[i] = rdata;
         cnt_d = wr_idx + CNTW'(1);
      end
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         keep_q  <= '0;
         valid_q <= 1'b0;
         wc_q    <= '0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         keep_q  <= keep_d;
         valid_q <= valid_d;
         wc_q    <= wc_d;
      end
   end

   assign out_data   = data_q;
   assign out_keep   = keep_q;
   assign out_valid  = valid_q;
   assign word_count = wc_q;

endmodule
